mem_readback_ctrl: RTL and testbench
====================================

Name: mem_readback_ctrl

Overview:
- Read-side counterpart of the testbench-to-memory preload path (tb2mem write port into ICCM/DCCM).
- After a program run, sequences reads over a contiguous word range of a core-local memory and streams each word out on a valid/ready channel, so the testbench or a debug consumer can dump and compare memory contents.
- Sits beside top_core on the memory's secondary read port.
- One read in flight at a time.

Parameters:
DW, 32, data width in bits; equals top_pkg::TL_DW
AW, 11, word address width
RD_LATENCY, 1, cycles from mem_re_o asserted to mem_rdata_i valid; legal range 1..4

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
start_i  input  1  pulse; begin a dump; sampled only in IDLE
base_addr_i  input  AW  first word address; sampled with start_i
num_words_i  input  AW+1  number of words to read; sampled with start_i
mem_re_o  output  1  memory read enable, one cycle per word
mem_raddr_o  output  AW  memory read address
mem_rdata_i  input  DW  memory read data, valid RD_LATENCY cycles after mem_re_o
out_valid_o  output  1  output word valid
out_data_o  output  DW  output word
out_addr_o  output  AW  address the output word was read from
out_ready_i  input  1  consumer accepts the word when high with out_valid_o
busy_o  output  1  high from the accepted start until done_o
done_o  output  1  one-cycle pulse when the dump completes

Behaviour:
- Reset (async assert, sync release) drives all outputs to 0: mem_re_o, mem_raddr_o, out_valid_o, out_data_o, out_addr_o, busy_o, done_o. FSM goes to IDLE.
- FSM states: IDLE, ISSUE, WAIT, HOLD, FINISH.
- IDLE
  - start_i=1 latches base_addr_i into addr_q and num_words_i into remaining_q. busy_o rises next cycle.
  - If num_words_i==0: go to FINISH.
  - Otherwise: go to ISSUE.
  - start_i while not in IDLE is ignored; no queuing.
- ISSUE
  - mem_re_o=1 and mem_raddr_o=addr_q for exactly one cycle. Load lat_cnt=RD_LATENCY-1, then go to WAIT.
- WAIT
  - Count lat_cnt down. The cycle that is RD_LATENCY cycles after ISSUE, capture mem_rdata_i into out_data_o and addr_q into out_addr_o, set out_valid_o=1, go to HOLD.
  - With RD_LATENCY=1, WAIT lasts one cycle.
- HOLD
  - out_valid_o, out_data_o and out_addr_o stay stable until out_ready_i=1.
  - On a handshake: out_valid_o clears next cycle, addr_q increments, remaining_q decrements.
  - If remaining_q becomes 0: go to FINISH. Otherwise: go to ISSUE.
  - Throughput: one word per RD_LATENCY+2 cycles when out_ready_i is held high.
- FINISH
  - done_o=1 for one cycle, busy_o=0, return to IDLE.
  - done_o pulses 1 cycle after the final handshake, or 2 cycles after start_i when num_words==0.
- Address arithmetic is modulo 2^AW: addr 2^AW-1 wraps to 0 without error.
- num_words_i maximum is 2^AW, i.e. the full memory exactly once.
- mem_re_o is never asserted outside ISSUE.
- out_valid_o never drops without a handshake, except on reset.
- Reset mid-dump aborts immediately: no done_o, output cleared.

Optional Feature:
- Macro: MEM_READBACK_CHECKSUM_EN.
- When defined, adds output checksum_o, DW bits.
  - Running sum modulo 2^DW of every accepted out_data_o.
  - Cleared to 0 when start_i is accepted.
  - Holds its value from done_o until the next start; reset value 0.
- When undefined, the port and its logic do not exist; all other behaviour is identical.

Test Plan:
- Basic dump: preload mem[0x010..0x013]={0x11111111,0x22222222,0x33333333,0x44444444}; start base=0x010, num=4, out_ready_i=1 -> four handshakes with out_addr_o 0x010..0x013 and matching data, one word per 3 cycles; done_o pulse; with checksum enabled, checksum_o=0xAAAAAAAA.
- Backpressure: num=2, out_ready_i low for 5 cycles on the first word -> out_valid_o/out_data_o/out_addr_o stable throughout; no second mem_re_o until that handshake.
- Wrap-around: base=0x7FE, num=4 -> mem_raddr_o sequence 0x7FE, 0x7FF, 0x000, 0x001.
- Zero length: num=0 -> no mem_re_o, no out_valid_o, done_o exactly 2 cycles after start_i.
- Latency and busy start: RD_LATENCY=3, num=1 -> data captured 3 cycles after mem_re_o; start_i pulsed again while busy -> ignored, exactly one done_o.
- Reset mid-dump: assert rst_i during HOLD of word 2 of 4 -> all outputs 0 immediately, no done_o; a later start base=0, num=1 completes normally.

Source files
------------

// File: rtl/mem_readback_ctrl_if.sv
// Bus bundle for mem_readback_ctrl.
// Carries the dump request, the memory secondary read port and the output stream.
// Port summary:
//   request : start_i, base_addr_i, num_words_i, busy_o, done_o
//   memory  : mem_re_o, mem_raddr_o, mem_rdata_i
//   stream  : out_valid_o, out_data_o, out_addr_o, out_ready_i
//   checksum_o exists only when MEM_READBACK_CHECKSUM_EN is defined.
// master = the controller, slave = the requester/memory/consumer side.
interface mem_readback_ctrl_if #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 11
);
   logic          start_i;
   logic [AW-1:0] base_addr_i;
   logic [AW:0]   num_words_i;
   logic          mem_re_o;
   logic [AW-1:0] mem_raddr_o;
   logic [DW-1:0] mem_rdata_i;
   logic          out_valid_o;
   logic [DW-1:0] out_data_o;
   logic [AW-1:0] out_addr_o;
   logic          out_ready_i;
   logic          busy_o;
   logic          done_o;
`ifdef MEM_READBACK_CHECKSUM_EN
   logic [DW-1:0] checksum_o;
`endif

   modport master (
      input  start_i, base_addr_i, num_words_i, mem_rdata_i, out_ready_i,
`ifdef MEM_READBACK_CHECKSUM_EN
      output checksum_o,
`endif
      output mem_re_o, mem_raddr_o, out_valid_o, out_data_o, out_addr_o,
             busy_o, done_o
   );

   modport slave (
      output start_i, base_addr_i, num_words_i, mem_rdata_i, out_ready_i,
`ifdef MEM_READBACK_CHECKSUM_EN
      input  checksum_o,
`endif
      input  mem_re_o, mem_raddr_o, out_valid_o, out_data_o, out_addr_o,
             busy_o, done_o
   );
endinterface

// File: rtl/mem_readback_ctrl.sv
// mem_readback_ctrl: reads a contiguous word range of a core-local memory
// through its secondary read port and streams each word out on valid/ready.
// One read is in flight at a time.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset
//   bus    - mem_readback_ctrl_if.master (request, memory port, output stream)
// Parameters: DW data width, AW word address width, RD_LATENCY (1..4)
// memory read latency in cycles.
// Optional: MEM_READBACK_CHECKSUM_EN adds checksum_o, the running sum
// modulo 2^DW of all accepted words of the current dump.
module mem_readback_ctrl #(
   parameter int unsigned DW         = 32,
   parameter int unsigned AW         = 11,
   parameter int unsigned RD_LATENCY = 1
) (
   input logic                clk_i,
   input logic                rst_i,
   mem_readback_ctrl_if.master bus
);

   localparam int unsigned CW = AW + 1;
   localparam int unsigned LW = 2;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, FINISH} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [CW-1:0] remaining_q, remaining_d;
   logic [LW-1:0] lat_q, lat_d;
   logic          re_q, re_d;
   logic [AW-1:0] raddr_q, raddr_d;
   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;
   logic [AW-1:0] oaddr_q, oaddr_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
`ifdef MEM_READBACK_CHECKSUM_EN
   logic [DW-1:0] sum_q, sum_d;
`endif

   // Next-state and next-output logic; every output is registered from here.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      lat_d       = lat_q;
      valid_d     = valid_q;
      data_d      = data_q;
      oaddr_d     = oaddr_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
`ifdef MEM_READBACK_CHECKSUM_EN
      sum_d       = sum_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               addr_d      = bus.base_addr_i;
               remaining_d = bus.num_words_i;
               busy_d      = 1'b1;
`ifdef MEM_READBACK_CHECKSUM_EN
               sum_d       = '0;
`endif
               state_d     = (bus.num_words_i == '0) ? FINISH : ISSUE;
            end
         end
         ISSUE: begin
            lat_d   = LW'(RD_LATENCY - 1);
            state_d = WAIT;
         end
         WAIT: begin
            if (lat_q == '0) begin
               valid_d = 1'b1;
               data_d  = bus.mem_rdata_i;
               oaddr_d = addr_q;
               state_d = HOLD;
            end else begin
               lat_d = lat_q - LW'(1);
            end
         end
         HOLD: begin
            if (bus.out_ready_i) begin
               valid_d     = 1'b0;
               addr_d      = addr_q + AW'(1);
               remaining_d = remaining_q - CW'(1);
`ifdef MEM_READBACK_CHECKSUM_EN
               sum_d       = sum_q + data_q;
`endif
               if (remaining_q == CW'(1)) begin
                  // Last word: done lands in the cycle right after the handshake.
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = FINISH;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         FINISH: begin
            // Busy is still high here only for a zero-length dump, whose
            // done pulse therefore comes one cycle later.
            done_d  = busy_q;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      re_d    = (state_d == ISSUE);
      raddr_d = (state_d == ISSUE) ? addr_d : raddr_q;
   end

   // State and output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         lat_q       <= '0;
         re_q        <= 1'b0;
         raddr_q     <= '0;
         valid_q     <= 1'b0;
         data_q      <= '0;
         oaddr_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef MEM_READBACK_CHECKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         lat_q       <= lat_d;
         re_q        <= re_d;
         raddr_q     <= raddr_d;
         valid_q     <= valid_d;
         data_q      <= data_d;
         oaddr_q     <= oaddr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef MEM_READBACK_CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   assign bus.mem_re_o    = re_q;
   assign bus.mem_raddr_o = raddr_q;
   assign bus.out_valid_o = valid_q;
   assign bus.out_data_o  = data_q;
   assign bus.out_addr_o  = oaddr_q;
   assign bus.busy_o      = busy_q;
   assign bus.done_o      = done_q;
`ifdef MEM_READBACK_CHECKSUM_EN
   assign bus.checksum_o  = sum_q;
`endif

endmodule

// File: tb/tb_mem_readback_ctrl.sv
// Testbench for mem_readback_ctrl: two instances (read latency 1 and 3)
// against a shared memory model; expected streams are built from the
// dump rules (address base+i modulo 2^AW, data = memory word).
module tb_mem_readback_ctrl;
   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 11;
   localparam int unsigned DEPTH = 2048;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_readback_ctrl_if #(.DW(DW), .AW(AW)) b1 ();
   mem_readback_ctrl_if #(.DW(DW), .AW(AW)) b3 ();

   mem_readback_ctrl #(.DW(DW), .AW(AW), .RD_LATENCY(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .bus(b1));
   mem_readback_ctrl #(.DW(DW), .AW(AW), .RD_LATENCY(3)) dut3 (
      .clk_i(clk), .rst_i(rst), .bus(b3));

   // Memory model: data valid only exactly RD_LATENCY cycles after a read.
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] p1_d = '0;
   logic          p1_v = 1'b0;
   logic [DW-1:0] p3_d [3];
   logic [2:0]    p3_v = '0;
   always @(posedge clk) begin
      p1_v    <= b1.mem_re_o;
      p1_d    <= mem[b1.mem_raddr_o];
      p3_v    <= {p3_v[1:0], b3.mem_re_o};
      p3_d[0] <= mem[b3.mem_raddr_o];
      p3_d[1] <= p3_d[0];
      p3_d[2] <= p3_d[1];
   end
   assign b1.mem_rdata_i = p1_v ? p1_d : 32'hBAD0_0001;
   assign b3.mem_rdata_i = p3_v[2] ? p3_d[2] : 32'hBAD0_0003;

   typedef struct {
      int            c;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ev_t;

   ev_t hs1_q[$], re1_q[$], hs3_q[$], re3_q[$];
   int  done1_q[$], done3_q[$], vr3_q[$];
   int  stab_err = 0;
   int  pend_err = 0;
   logic pv1 = 0, pr1 = 0, pv3 = 0, pr3 = 0;
   logic [DW-1:0] pd1, pd3;
   logic [AW-1:0] pa1, pa3;

   // Monitor: logs reads, handshakes and done pulses mid-cycle; counts
   // pending words that changed without a handshake.
   always @(negedge clk) begin
      if (rst) begin
         pv1 = 1'b0;
         pv3 = 1'b0;
      end else begin
         if (b1.mem_re_o) begin
            re1_q.push_back('{cyc, b1.mem_raddr_o, '0});
            if (b1.out_valid_o) pend_err++;
         end
         if (b1.out_valid_o && b1.out_ready_i)
            hs1_q.push_back('{cyc, b1.out_addr_o, b1.out_data_o});
         if (b1.done_o) done1_q.push_back(cyc);
         if (pv1 && !pr1 && (!b1.out_valid_o || b1.out_data_o !== pd1 ||
                             b1.out_addr_o !== pa1)) stab_err++;
         pv1 = b1.out_valid_o; pr1 = b1.out_ready_i;
         pd1 = b1.out_data_o;  pa1 = b1.out_addr_o;

         if (b3.mem_re_o) begin
            re3_q.push_back('{cyc, b3.mem_raddr_o, '0});
            if (b3.out_valid_o) pend_err++;
         end
         if (b3.out_valid_o && !pv3) vr3_q.push_back(cyc);
         if (b3.out_valid_o && b3.out_ready_i)
            hs3_q.push_back('{cyc, b3.out_addr_o, b3.out_data_o});
         if (b3.done_o) done3_q.push_back(cyc);
         if (pv3 && !pr3 && (!b3.out_valid_o || b3.out_data_o !== pd3 ||
                             b3.out_addr_o !== pa3)) stab_err++;
         pv3 = b3.out_valid_o; pr3 = b3.out_ready_i;
         pd3 = b3.out_data_o;  pa3 = b3.out_addr_o;
      end
   end

   int   n_tests = 0;
   int   n_fail  = 0;
   logic rand_rdy = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) b1.out_ready_i = 1'($urandom_range(0, 1));
   endtask

   // One dump on the latency-1 instance. mode 0: ready high, timing checked;
   // 1: random ready; 2: first word held off for 5 cycles.
   task automatic run1(input logic [AW-1:0] base, input int num, input int mode);
      int h0, r0, d0, s, nh;
      logic [DW-1:0] sum;
      logic [AW-1:0] ea;
      h0 = hs1_q.size(); r0 = re1_q.size(); d0 = done1_q.size();
      rand_rdy = (mode == 1);
      b1.out_ready_i = (mode != 2);
      b1.base_addr_i = base;
      b1.num_words_i = (AW+1)'(num);
      b1.start_i     = 1'b1;
      s = cyc;
      tick();
      b1.start_i = 1'b0;
      check("busy_rise", 64'(b1.busy_o), 64'(1));
      if (mode == 2) begin
         for (int k = 0; k < 50 && !b1.out_valid_o; k++) tick();
         repeat (5) tick();
         check("bp_single_read", 64'(re1_q.size() - r0), 64'(1));
         check("bp_no_handshake", 64'(hs1_q.size() - h0), 64'(0));
         b1.out_ready_i = 1'b1;
      end
      for (int k = 0; k < num * 40 + 50 && done1_q.size() == d0; k++) tick();
      repeat (3) tick();
      rand_rdy = 1'b0;
      check("done_count", 64'(done1_q.size() - d0), 64'(1));
      check("busy_after", 64'(b1.busy_o), 64'(0));
      nh = hs1_q.size() - h0;
      check("hs_count", 64'(nh), 64'(num));
      check("re_count", 64'(re1_q.size() - r0), 64'(num));
      sum = '0;
      for (int i = 0; i < num && i < nh && (r0 + i) < re1_q.size(); i++) begin
         ea = AW'((int'(base) + i) % DEPTH);
         check($sformatf("re_addr[%0d]", i), 64'(re1_q[r0+i].a), 64'(ea));
         check($sformatf("hs_addr[%0d]", i), 64'(hs1_q[h0+i].a), 64'(ea));
         check($sformatf("hs_data[%0d]", i), 64'(hs1_q[h0+i].d), 64'(mem[ea]));
         sum += mem[ea];
         if (mode == 0 && i > 0)
            check($sformatf("hs_spacing[%0d]", i),
                  64'(hs1_q[h0+i].c - hs1_q[h0+i-1].c), 64'(3));
      end
      if (done1_q.size() > d0) begin
         if (num == 0)
            check("done_zero_lat", 64'(done1_q[d0] - s), 64'(2));
         else if (nh > 0)
            check("done_lat", 64'(done1_q[d0] - hs1_q[hs1_q.size()-1].c), 64'(1));
      end
      if (mode == 0 && num > 0 && re1_q.size() > r0)
         check("first_re_lat", 64'(re1_q[r0].c - s), 64'(1));
`ifdef MEM_READBACK_CHECKSUM_EN
      check("checksum", 64'(b1.checksum_o), 64'(sum));
`endif
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int h0, d0, r0, s3;
      logic [AW-1:0] base3;
      rst = 1'b1;
      b1.start_i = 0; b1.base_addr_i = '0; b1.num_words_i = '0; b1.out_ready_i = 1;
      b3.start_i = 0; b3.base_addr_i = '0; b3.num_words_i = '0; b3.out_ready_i = 1;
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
      mem[16] = 32'h1111_1111; mem[17] = 32'h2222_2222;
      mem[18] = 32'h3333_3333; mem[19] = 32'h4444_4444;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl1", 64'({b1.mem_re_o, b1.out_valid_o, b1.busy_o, b1.done_o}), 64'(0));
      check("rst_raddr1", 64'(b1.mem_raddr_o), 64'(0));
      check("rst_data1", 64'(b1.out_data_o), 64'(0));
      check("rst_oaddr1", 64'(b1.out_addr_o), 64'(0));
      check("rst_ctrl3", 64'({b3.mem_re_o, b3.out_valid_o, b3.busy_o, b3.done_o}), 64'(0));
      rst = 1'b0;
      tick();

      run1(11'h010, 4, 0);                      // basic dump
`ifdef MEM_READBACK_CHECKSUM_EN
      check("checksum_basic", 64'(b1.checksum_o), 64'(32'hAAAA_AAAA));
`endif
      run1(AW'($urandom_range(0, DEPTH-1)), 2, 2); // backpressure
      run1(11'h7FE, 4, 0);                      // wrap-around
      run1(11'h123, 0, 0);                      // zero length
      for (int t = 0; t < 6; t++)
         run1(AW'($urandom_range(0, DEPTH-1)), $urandom_range(1, 9), $urandom_range(0, 1));
      run1(AW'($urandom_range(0, DEPTH-1)), DEPTH, 0); // whole memory once

      // Latency 3, single word, second start while busy is ignored.
      base3 = AW'($urandom_range(0, DEPTH-1));
      b3.base_addr_i = base3; b3.num_words_i = 12'd1; b3.start_i = 1'b1;
      s3 = cyc;
      tick();
      b3.start_i = 1'b0;
      repeat (2) tick();
      b3.base_addr_i = base3 + AW'(5); b3.num_words_i = 12'd3; b3.start_i = 1'b1;
      tick();
      b3.start_i = 1'b0;
      for (int k = 0; k < 100 && done3_q.size() == 0; k++) tick();
      repeat (8) tick();
      check("l3_done_count", 64'(done3_q.size()), 64'(1));
      check("l3_re_count", 64'(re3_q.size()), 64'(1));
      check("l3_hs_count", 64'(hs3_q.size()), 64'(1));
      if (re3_q.size() > 0 && vr3_q.size() > 0 && hs3_q.size() > 0 && done3_q.size() > 0) begin
         check("l3_re_lat", 64'(re3_q[0].c - s3), 64'(1));
         check("l3_valid_lat", 64'(vr3_q[0] - re3_q[0].c), 64'(4));
         check("l3_addr", 64'(hs3_q[0].a), 64'(base3));
         check("l3_data", 64'(hs3_q[0].d), 64'(mem[base3]));
         check("l3_done_lat", 64'(done3_q[0] - hs3_q[0].c), 64'(1));
      end

      // Reset while word 2 of 4 is waiting for the consumer.
      h0 = hs1_q.size(); d0 = done1_q.size(); r0 = re1_q.size();
      b1.base_addr_i = AW'($urandom_range(0, DEPTH-1)); b1.num_words_i = 12'd4;
      b1.out_ready_i = 1'b1; b1.start_i = 1'b1;
      tick();
      b1.start_i = 1'b0;
      for (int k = 0; k < 50 && hs1_q.size() == h0; k++) tick();
      b1.out_ready_i = 1'b0;
      for (int k = 0; k < 50 && !b1.out_valid_o; k++) tick();
      check("mid_valid_word2", 64'(b1.out_valid_o), 64'(1));
      rst = 1'b1;
      #1;
      check("mid_rst_ctrl", 64'({b1.mem_re_o, b1.out_valid_o, b1.busy_o, b1.done_o}), 64'(0));
      check("mid_rst_data", 64'(b1.out_data_o), 64'(0));
      check("mid_rst_addrs", 64'({b1.out_addr_o, b1.mem_raddr_o}), 64'(0));
`ifdef MEM_READBACK_CHECKSUM_EN
      check("mid_rst_checksum", 64'(b1.checksum_o), 64'(0));
`endif
      repeat (3) tick();
      rst = 1'b0;
      repeat (3) tick();
      check("mid_no_done", 64'(done1_q.size() - d0), 64'(0));
      check("mid_hs_count", 64'(hs1_q.size() - h0), 64'(1));
      check("mid_re_count", 64'(re1_q.size() - r0), 64'(2));
      run1(11'h000, 1, 0);

      check("hold_stable", 64'(stab_err), 64'(0));
      check("re_while_pending", 64'(pend_err), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
